// File: rtl/boton_pkg.sv
// boton_pkg: shared types and helpers for the button event classifier.
//   estado_t  - FSM states (ESPERA/PRESION2 only reachable with BOTON_DOBLE_EN)
//   ciclos_ms - clock cycles per millisecond tick
//   ancho_ms  - width of the saturating ms counter
package boton_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        PRESION,
        LARGO,
        ESPERA,
        PRESION2
    } estado_t;

    function automatic int ciclos_ms(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    // Wide enough to hold the larger of the two thresholds without wrapping.
    function automatic int ancho_ms(input int largo_ms, input int doble_ms);
        int m;
        m = (largo_ms > doble_ms) ? largo_ms : doble_ms;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/boton_eventos_if.sv
// boton_eventos_if: debounced level in, event strobes out.
//   rebotado   - clean button level, 1 = pressed
//   corto      - short-press strobe
//   largo      - long-press strobe
//   doble      - double-press strobe
//   presionado - registered copy of rebotado
// master = debouncer/game side, slave = boton_eventos.
interface boton_eventos_if;
    logic rebotado;
    logic corto;
    logic largo;
    logic doble;
    logic presionado;

    modport master (output rebotado, input corto, largo, doble, presionado);
    modport slave  (input rebotado, output corto, largo, doble, presionado);
endinterface

// File: rtl/boton_eventos_contador_ms.sv
// contador_ms: millisecond time base for the button FSM.
//   clk, rst_n - clock, async active-low reset
//   limpiar    - synchronous clear of prescaler and ms count
//   ms         - elapsed ms since last clear, saturating
//   tick       - high in the last cycle of each ms (ms increments on the next edge)
module contador_ms #(
    parameter int CICLOS = 50_000,
    parameter int ANCHO  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             limpiar,
    output logic [ANCHO-1:0] ms,
    output logic             tick
);
    localparam int PRE_W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CICLOS - 1);

    logic [PRE_W-1:0] pre;

    assign tick = (pre == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            ms  <= '0;
        end else if (limpiar) begin
            pre <= '0;
            ms  <= '0;
        end else if (tick) begin
            pre <= '0;
            if (ms != '1)
                ms <= ms + ANCHO'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end
endmodule

// File: rtl/boton_eventos.sv
// boton_eventos: turns a debounced button level into one-cycle event strobes.
//   clk, rst_n - clock, async active-low reset
//   bus        - boton_eventos_if.slave (rebotado in; corto/largo/doble/presionado out)
// Optional: define BOTON_DOBLE_EN to enable double-press detection; this
// delays corto until the DOBLE_MS window after a short release has expired.
module boton_eventos
    import boton_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int LARGO_MS = 5000,
    parameter int DOBLE_MS = 300
) (
    input  logic           clk,
    input  logic           rst_n,
    boton_eventos_if.slave bus
);
    localparam int CICLOS = ciclos_ms(CLK_FREQ);
    localparam int ANCHO  = ancho_ms(LARGO_MS, DOBLE_MS);
    localparam logic [ANCHO-1:0] FIN_LARGO = ANCHO'(LARGO_MS - 1);

    estado_t          estado, estado_sig;
    logic             previo;
    logic             sube;
    logic             limpiar;
    logic             tick;
    logic [ANCHO-1:0] ms;
    logic             llega_largo;

    // previo resets to 1 so a button held through reset must be released
    // before it can produce a press edge.
    assign sube        = bus.rebotado & ~previo;
    // The threshold is "reached" on the edge where ms steps onto LARGO_MS.
    assign llega_largo = tick && (ms == FIN_LARGO);

`ifdef BOTON_DOBLE_EN
    localparam logic [ANCHO-1:0] FIN_DOBLE = ANCHO'(DOBLE_MS - 1);
    logic llega_doble;
    assign llega_doble = tick && (ms == FIN_DOBLE);
`endif

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:   if (sube) estado_sig = PRESION;
            // Threshold is checked first so a simultaneous release is a long press.
            PRESION:  if (llega_largo)        estado_sig = LARGO;
`ifdef BOTON_DOBLE_EN
                      else if (!bus.rebotado) estado_sig = ESPERA;
`else
                      else if (!bus.rebotado) estado_sig = REPOSO;
`endif
            LARGO:    if (!bus.rebotado) estado_sig = REPOSO;
`ifdef BOTON_DOBLE_EN
            // A press landing exactly on window expiry counts as too late.
            ESPERA:   if (llega_doble)        estado_sig = REPOSO;
                      else if (sube)          estado_sig = PRESION2;
            PRESION2: if (llega_largo)        estado_sig = LARGO;
                      else if (!bus.rebotado) estado_sig = REPOSO;
`endif
            default:  estado_sig = REPOSO;
        endcase
    end

    // Every state change restarts the time base.
    assign limpiar = (estado_sig != estado);

    contador_ms #(
        .CICLOS (CICLOS),
        .ANCHO  (ANCHO)
    ) u_contador (
        .clk     (clk),
        .rst_n   (rst_n),
        .limpiar (limpiar),
        .ms      (ms),
        .tick    (tick)
    );

    // Strobes are decoded from the transition being taken, so each gesture
    // yields exactly one pulse and they are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= REPOSO;
            previo         <= 1'b1;
            bus.presionado <= 1'b0;
            bus.corto      <= 1'b0;
            bus.largo      <= 1'b0;
        end else begin
            estado         <= estado_sig;
            previo         <= bus.rebotado;
            bus.presionado <= bus.rebotado;
            bus.corto      <= (estado_sig == REPOSO) && (estado == PRESION || estado == ESPERA);
            bus.largo      <= (estado_sig == LARGO) && (estado != LARGO);
        end
    end

`ifdef BOTON_DOBLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.doble <= 1'b0;
        else        bus.doble <= (estado == PRESION2) && (estado_sig == REPOSO);
    end
`else
    assign bus.doble = 1'b0;
`endif

endmodule

// File: tb/tb_boton_eventos.sv
// tb_boton_eventos: self-checking bench for boton_eventos.
// Gestures are described as press/release durations; expected strobe times
// are derived from those durations (hold >= LARGO window => largo at
// press+L, otherwise corto at release, or at release+D with BOTON_DOBLE_EN).
module tb_boton_eventos;
    localparam int CLK_FREQ = 10_000;
    localparam int LARGO_MS = 20;
    localparam int DOBLE_MS = 10;
    localparam int CPM = CLK_FREQ / 1000;
    localparam int L   = LARGO_MS * CPM;
    localparam int D   = DOBLE_MS * CPM;
`ifdef BOTON_DOBLE_EN
    localparam int WIN   = D;
    localparam int TOL_C = 1;
`else
    localparam int WIN   = 0;
    localparam int TOL_C = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    boton_eventos_if bus_if();

    boton_eventos #(
        .CLK_FREQ (CLK_FREQ),
        .LARGO_MS (LARGO_MS),
        .DOBLE_MS (DOBLE_MS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int corto_t[$];
    int largo_t[$];
    int doble_t[$];

    // Each edge gets a number; strobes are logged with the number of the
    // edge that registered them. Also checks presionado lag and exclusivity.
    always @(posedge clk) begin
        logic reb;
        logic rst_edge;
        cyc      = cyc + 1;
        reb      = bus_if.rebotado;
        rst_edge = rst_n;
        #1;
        if (rst_n && rst_edge) begin
            if (bus_if.corto) corto_t.push_back(cyc);
            if (bus_if.largo) largo_t.push_back(cyc);
            if (bus_if.doble) doble_t.push_back(cyc);
            vectors++;
            if (bus_if.presionado !== reb) begin
                errors++;
                $display("FAIL presionado cyc=%0d: got %b, want %b", cyc, bus_if.presionado, reb);
            end
            vectors++;
            if (int'(bus_if.corto) + int'(bus_if.largo) + int'(bus_if.doble) > 1) begin
                errors++;
                $display("FAIL exclusive cyc=%0d: got c/l/d=%b%b%b, want at most one",
                         cyc, bus_if.corto, bus_if.largo, bus_if.doble);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        corto_t.delete();
        largo_t.delete();
        doble_t.delete();
    endtask

    // Hold for h cycles; p/r are the edges sampling the press/release.
    task automatic pulsar(input int h, output int p, output int r);
        bus_if.rebotado = 1'b1;
        p = cyc + 1;
        idle(h);
        bus_if.rebotado = 1'b0;
        r = cyc + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.rebotado = 1'b0;
        idle(3);
        vectors++;
        if ({bus_if.corto, bus_if.largo, bus_if.doble, bus_if.presionado} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out: got %b%b%b%b, want 0000",
                     bus_if.corto, bus_if.largo, bus_if.doble, bus_if.presionado);
        end
        rst_n = 1'b1;
        idle(5);
        vectors++;
        if ({bus_if.corto, bus_if.largo, bus_if.doble, bus_if.presionado} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_out: got %b%b%b%b, want 0000",
                     bus_if.corto, bus_if.largo, bus_if.doble, bus_if.presionado);
        end
    endtask

    task automatic test_corto(input int h);
        int p, r;
        clear_logs();
        pulsar(h, p, r);
        idle(D + 20);
        vectors++;
        if (corto_t.size() != 1) begin
            errors++;
            $display("FAIL corto_count h=%0d: got %0d, want 1", h, corto_t.size());
        end else begin
            vectors++;
            if (corto_t[0] < r + WIN - TOL_C || corto_t[0] > r + WIN + TOL_C) begin
                errors++;
                $display("FAIL corto_time h=%0d: got %0d, want %0d", h, corto_t[0] - r, WIN);
            end
        end
        vectors++;
        if (largo_t.size() + doble_t.size() != 0) begin
            errors++;
            $display("FAIL corto_other h=%0d: got l=%0d d=%0d, want 0", h, largo_t.size(), doble_t.size());
        end
    endtask

    task automatic test_largo(input int h);
        int p, r;
        clear_logs();
        pulsar(h, p, r);
        idle(D + 20);
        vectors++;
        if (largo_t.size() != 1) begin
            errors++;
            $display("FAIL largo_count h=%0d: got %0d, want 1", h, largo_t.size());
        end else begin
            vectors++;
            if (largo_t[0] < p + L - 1 || largo_t[0] > p + L + 1) begin
                errors++;
                $display("FAIL largo_time h=%0d: got %0d, want %0d+-1", h, largo_t[0] - p, L);
            end
        end
        vectors++;
        if (corto_t.size() + doble_t.size() != 0) begin
            errors++;
            $display("FAIL largo_other h=%0d: got c=%0d d=%0d, want 0", h, corto_t.size(), doble_t.size());
        end
    endtask

    // Press 30, gap 40, press 30: a double press, or two shorts without the feature.
    task automatic test_back_to_back();
        int p1, r1, p2, r2;
        clear_logs();
        pulsar(30, p1, r1);
        idle(40);
        pulsar(30, p2, r2);
        idle(D + 20);
`ifdef BOTON_DOBLE_EN
        vectors++;
        if (doble_t.size() != 1 || corto_t.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got d=%0d c=%0d, want d=1 c=0", doble_t.size(), corto_t.size());
        end else begin
            vectors++;
            if (doble_t[0] != r2) begin
                errors++;
                $display("FAIL b2b_time: got %0d, want %0d", doble_t[0], r2);
            end
        end
`else
        vectors++;
        if (corto_t.size() != 2 || doble_t.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got c=%0d d=%0d, want c=2 d=0", corto_t.size(), doble_t.size());
        end else begin
            vectors++;
            if (corto_t[0] != r1 || corto_t[1] != r2) begin
                errors++;
                $display("FAIL b2b_time: got %0d/%0d, want %0d/%0d", corto_t[0], corto_t[1], r1, r2);
            end
        end
`endif
        vectors++;
        if (largo_t.size() != 0) begin
            errors++;
            $display("FAIL b2b_largo: got %0d, want 0", largo_t.size());
        end
    endtask

    task automatic test_reset_held();
        rst_n = 1'b0;
        bus_if.rebotado = 1'b1;
        idle(3);
        rst_n = 1'b1;
        clear_logs();
        idle(500);
        vectors++;
        if (corto_t.size() + largo_t.size() + doble_t.size() != 0) begin
            errors++;
            $display("FAIL held_reset: got %0d pulses, want 0",
                     corto_t.size() + largo_t.size() + doble_t.size());
        end
        bus_if.rebotado = 1'b0;
        idle(20);
        test_corto(30);
    endtask

    task automatic test_reset_mid();
        clear_logs();
        bus_if.rebotado = 1'b1;
        idle(150);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_if.corto, bus_if.largo, bus_if.doble, bus_if.presionado} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_out: got %b%b%b%b, want 0000",
                     bus_if.corto, bus_if.largo, bus_if.doble, bus_if.presionado);
        end
        idle(10);
        rst_n = 1'b1;
        idle(300);
        bus_if.rebotado = 1'b0;
        idle(D + 20);
        vectors++;
        if (corto_t.size() + largo_t.size() + doble_t.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pulses: got c=%0d l=%0d d=%0d, want 0",
                     corto_t.size(), largo_t.size(), doble_t.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int kind, h1, h2, g, p1, r1, p2, r2;
            int ec[$];
            int el[$];
            int ed[$];
            clear_logs();
            kind = $urandom_range(0, 2);
            h1 = (kind == 1) ? $urandom_range(L + 10, L + 60) : $urandom_range(10, L - 10);
            pulsar(h1, p1, r1);
            if (kind == 2) begin
                g = $urandom_range(5, D - 10);
                idle(g);
                h2 = $urandom_range(10, L - 10);
                pulsar(h2, p2, r2);
            end
            idle(D + 30);
            if (kind == 1)      el.push_back(p1 + L);
            else if (kind == 0) ec.push_back(r1 + WIN);
            else begin
`ifdef BOTON_DOBLE_EN
                ed.push_back(r2);
`else
                ec.push_back(r1);
                ec.push_back(r2);
`endif
            end
            for (int k = 0; k < 3; k++) begin
                int obs[$];
                int esp[$];
                int tol;
                case (k)
                    0:       begin obs = corto_t; esp = ec; tol = TOL_C; end
                    1:       begin obs = largo_t; esp = el; tol = 1;     end
                    default: begin obs = doble_t; esp = ed; tol = 0;     end
                endcase
                vectors++;
                if (obs.size() != esp.size()) begin
                    errors++;
                    $display("FAIL rnd_count it=%0d kind=%0d strobe=%0d: got %0d, want %0d",
                             it, kind, k, obs.size(), esp.size());
                end else begin
                    foreach (esp[i]) begin
                        vectors++;
                        if (obs[i] < esp[i] - tol || obs[i] > esp[i] + tol) begin
                            errors++;
                            $display("FAIL rnd_time it=%0d strobe=%0d: got %0d, want %0d+-%0d",
                                     it, k, obs[i], esp[i], tol);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bus_if.rebotado = 1'b0;
        test_reset();
        test_corto(50);
        test_largo(300);
        test_corto(L - 3);
        test_largo(L + 3);
        test_back_to_back();
        test_reset_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/boton_eventos.md
# boton_eventos

Classifies the debounced button level into one-cycle event pulses (short press, long press, and optionally double press) for the Tamagotchi control FSM. It sits directly downstream of the button debouncer, one instance per button. It consumes the debouncer's clean level and emits single-cycle strobes that the game logic samples without its own edge detection.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `LARGO_MS`, default 5000: hold time in ms that qualifies as a long press (Tamagotchi reset/test gesture).
- `DOBLE_MS`, default 300: window in ms after a short release in which a second press makes a double press. Used only with `BOTON_DOBLE_EN`.
- `clk`, input, 1: system clock. All logic is rising-edge.
- `rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `rebotado`, input, 1: debounced button level, synchronous to `clk`, 1 = pressed.
- `corto`, output, 1: one-cycle pulse for a short press.
- `largo`, output, 1: one-cycle pulse when the hold reaches `LARGO_MS`.
- `doble`, output, 1: one-cycle pulse for a double press. Tied 0 without the macro.
- `presionado`, output, 1: registered copy of `rebotado` (level).

## Operation
- **Reset values**
  - All outputs 0, state REPOSO, counters 0.
  - The previous-level register resets to 1. A button already held at reset release generates no events until it is seen at 0.
- **Press detection:** press edge = `rebotado`=1 while the previous level was 0. Release edge = the opposite transition.
- **Time base:** a prescaler counts `CLK_FREQ/1000` cycles per ms tick. A ms counter of width `$clog2(max(LARGO_MS,DOBLE_MS)+1)` saturates at its maximum and never wraps. Both counters clear on every state change.
- **FSM states**
  - REPOSO
    - Press edge → PRESION.
  - PRESION
    - ms count = `LARGO_MS` → pulse `largo`, go to LARGO.
    - Release before that → emit the short-press outcome (see Configuration).
  - LARGO
    - Wait for release → REPOSO. No `corto` is emitted.
  - ESPERA (macro only)
    - Press edge before `DOBLE_MS` → PRESION2.
    - Window expiry → pulse `corto`, go to REPOSO.
  - PRESION2 (macro only)
    - Release before `LARGO_MS` → pulse `doble`, go to REPOSO.
    - Reaching `LARGO_MS` → pulse `largo`, go to LARGO.
- **Exclusivity:** at most one of `corto`, `largo`, `doble` is high in any cycle. Each gesture produces exactly one pulse.
- **Reset mid-gesture:** all state is dropped, no pulse is emitted, and a fresh 0→1 transition is required afterwards.

## Timing
- Edge sampled at cycle N: the state changes at N+1. Pulse outputs are registered and high during cycle N+1 only.
- Short press without the macro: `corto` is high in the cycle after the release is sampled.
- Long press: `largo` is high in the cycle after the ms counter reaches `LARGO_MS`. That is `LARGO_MS*CLK_FREQ/1000` cycles after PRESION entry, ±1 cycle.
- `presionado` lags `rebotado` by 1 cycle.
- A release and the threshold reached in the same cycle resolve as `largo`: the threshold has priority.

## Configuration
- `BOTON_DOBLE_EN` defined:
  - Release from PRESION goes to ESPERA.
  - `corto` is delayed until the `DOBLE_MS` window expires.
  - `doble` is driven by the FSM.
- `BOTON_DOBLE_EN` undefined:
  - Release from PRESION pulses `corto` immediately and goes to REPOSO.
  - ESPERA and PRESION2 are not synthesized; `doble` is constant 0.

## Structure
- Package `boton_pkg` holds:
  - the state enum (REPOSO, PRESION, LARGO, ESPERA, PRESION2);
  - the `CICLOS_MS = CLK_FREQ/1000` constant function;
  - the counter width function.
- Sub-module `contador_ms`: prescaler plus saturating ms counter, with a `limpiar` input, `ms` output and `tick` output. It is instantiated once.

## Test plan
Bench parameters: `CLK_FREQ`=10_000 (10 cycles/ms), `LARGO_MS`=20, `DOBLE_MS`=10.
- **Short press, macro off:** hold `rebotado` 50 cycles, then release → one `corto` pulse one cycle after the release is sampled; no `largo`.
- **Long press:** hold 300 cycles → `largo` pulses once at 200±1 cycles after the press; no `corto` on release.
- **Double press, macro on:** press 30 cycles, release 40 cycles, press 30 cycles, release → exactly one `doble`, no `corto`.
- **Window expiry, macro on:** single 30-cycle press → `corto` appears 100±1 cycles after the release.
- **Held through reset:** `rst_n` released with `rebotado`=1 for 500 cycles → no pulses. Then release, press, release → one `corto`.
- **Reset mid-hold:** assert `rst_n` at 150 cycles into a press → all outputs 0 immediately; no `largo` after reset deasserts while still held.
